// File: rtl/sync_fifo_flags_pkg.sv
// Shared constants and parameter helpers for the single-clock flagged FIFO.
package sync_fifo_flags_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Default almost-empty level: two words or fewer left.
  localparam int DEFAULT_AEMPTY_THRESH = 2;

  // Pointer width for a power-of-two depth.
  function automatic int addr_size(input int depth);
    return $clog2(depth);
  endfunction

  // Default almost-full level: two free slots or fewer.
  function automatic int default_afull_thresh(input int depth);
    return depth - 2;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH simple dual-port RAM: synchronous write, read port either
// registered (loaded only on rd_en) or combinational.
module sync_fifo_mem
  import sync_fifo_flags_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int REG_OUT = 1,
  localparam int ADDR_SIZE = addr_size(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  // Storage is deliberately left unreset so it maps onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      // Registered read: output holds until the next accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data <= '0;
        end else if (rd_en) begin
          rd_data <= mem[rd_addr];
        end
      end
    end else begin : g_comb_out
      // Fall-through read: head word is always presented.
      assign rd_data = mem[rd_addr];
      // Read enable and reset have no role on a combinational port.
      logic unused_ctrl;
      assign unused_ctrl = rd_en ^ rst_n;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow errors and standard or fall-through read mode.
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = default_afull_thresh(DEPTH),
  parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH,
  localparam int ADDR_SIZE    = addr_size(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_inc,
  input  logic [WIDTH-1:0]     i_datain,
  input  logic                 i_rd_inc,
  output logic [WIDTH-1:0]     o_dataout,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [ADDR_SIZE:0]   o_count,
  output logic                 o_overflow,
  input  logic                 i_clr_err,
  output logic                 o_underflow
);

  localparam logic [ADDR_SIZE:0] DEPTH_CNT  = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AFULL_CNT  = (ADDR_SIZE+1)'(AFULL_THRESH);
  localparam logic [ADDR_SIZE:0] AEMPTY_CNT = (ADDR_SIZE+1)'(AEMPTY_THRESH);
  localparam int REG_OUT = (FWFT == FIFO_MODE_STD) ? 1 : 0;

  logic [ADDR_SIZE-1:0] wr_ptr_reg;
  logic [ADDR_SIZE-1:0] rd_ptr_reg;
  logic [ADDR_SIZE:0]   count_reg;
  logic [ADDR_SIZE:0]   count_next;
  logic                 overflow_reg;
  logic                 overflow_next;
  logic                 underflow_reg;
  logic                 underflow_next;
  logic                 full;
  logic                 empty;
  logic                 wr_accept;
  logic                 rd_accept;

  // Status comes only from the count register, never from the requests.
  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);

  assign wr_accept = i_wr_inc && !full;
  assign rd_accept = i_rd_inc && !empty;

  // Next occupancy and sticky error state; a new error beats a clear.
  always_comb begin
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (wr_accept && !rd_accept) begin
      count_next = count_reg + 1'b1;
    end else if (rd_accept && !wr_accept) begin
      count_next = count_reg - 1'b1;
    end
    if (i_clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (i_wr_inc && full) begin
      overflow_next = 1'b1;
    end
    if (i_rd_inc && empty) begin
      underflow_next = 1'b1;
    end
  end

  // Pointer, count and error registers; pointers wrap at DEPTH naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  sync_fifo_mem #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .REG_OUT (REG_OUT)
  ) u_mem (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (i_datain),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_reg),
    .rd_data (o_dataout)
  );

  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (count_reg >= AFULL_CNT);
  assign o_almost_empty = (count_reg <= AEMPTY_CNT);
  assign o_count        = count_reg;
  assign o_overflow     = overflow_reg;
  assign o_underflow    = underflow_reg;

endmodule
